// File: rtl/c16_tap_pkg.sv
// Shared types and constants for the C16 TAP cassette player.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package c16_tap_pkg;

    typedef enum logic [2:0] {
        ST_HEADER,
        ST_FETCH,
        ST_EXT0,
        ST_EXT1,
        ST_EXT2,
        ST_RUN_A,
        ST_RUN_B,
        ST_DONE
    } state_t;

    localparam int HEADER_LEN     = 20;
    localparam int VERSION_OFFSET = 12;
    localparam int SCALE_SHIFT    = 3;
    localparam int V0_ZERO_LEN    = 2048;
    localparam int PLEN_W         = 24;

    // Header version field: only the low two bits matter, and 3 behaves as 2.
    function automatic logic [1:0] clamp_version(input logic [7:0] b);
        return (b[1:0] == 2'd3) ? 2'd2 : b[1:0];
    endfunction

endpackage

// File: rtl/tap_fifo.sv
// Synchronous byte FIFO with registered full/empty flags.
// Latency: popped data appears on rd_data the cycle after rd.
// Backpressure: writes are dropped while full; reads ignored while empty.
module tap_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    // Occupancy after this cycle's accepted write/read.
    always_comb begin
        count_nxt = count;
        case ({do_wr, do_rd})
            2'b10:   count_nxt = count + CNT_ONE;
            2'b01:   count_nxt = count - CNT_ONE;
            default: count_nxt = count;
        endcase
    end

    // Storage array; contents need no reset since pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wr_data;
        end
    end

    // Pointers, registered flags and the registered read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
            rd_data <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + PTR_ONE;
            end
            if (do_rd) begin
                rptr    <= rptr + PTR_ONE;
                rd_data <= mem[rptr];
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_FULL);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/c16_tap_player.sv
// Parses a C16 TAP byte stream and regenerates CASS_READ / CASS_SENSE.
// Latency: <=3 cycles from FIFO non-empty in FETCH to the RUN_A edge on CASS_READ.
// Backpressure: tap_full (registered) stalls the loader; playback stalls on underrun.
module c16_tap_player
    import c16_tap_pkg::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       CLK28,
    input  logic       RESET,
    input  logic       tick_en,
    input  logic       tap_reset,
    input  logic       tap_wr,
    input  logic [7:0] tap_data,
    input  logic       tap_eof,
    output logic       tap_full,
    input  logic       play,
    input  logic       CASS_MOTOR,
    output logic       CASS_READ,
    output logic       CASS_SENSE,
    output logic [1:0] version,
    output logic       done
);

    localparam int HCW = 5;
    localparam logic [HCW-1:0]    HDR_END  = HCW'(HEADER_LEN);
    localparam logic [HCW-1:0]    VER_SEEN = HCW'(VERSION_OFFSET + 1);
    localparam logic [HCW-1:0]    HDR_ONE  = HCW'(1);
    localparam logic [PLEN_W-1:0] ZERO_LEN = PLEN_W'(V0_ZERO_LEN);
    localparam logic [PLEN_W-1:0] ONE      = PLEN_W'(1);

    logic              flush;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [7:0]        fifo_dat;

    state_t            state;
    state_t            state_nxt;
    logic              pend;
    logic              pend_nxt;
    logic [HCW-1:0]    hdr_cnt;
    logic [HCW-1:0]    hdr_nxt;
    logic [1:0]        ver_q;
    logic [1:0]        ver_nxt;
    logic [PLEN_W-1:0] plen;
    logic [PLEN_W-1:0] plen_nxt;
    logic [PLEN_W-1:0] cnt;
    logic [PLEN_W-1:0] cnt_nxt;
    logic [PLEN_W-1:0] p_new;
    logic [PLEN_W-1:0] p_eff;
    logic [PLEN_W-1:0] p_half;
    logic              start;
    logic              read_q;
    logic              read_nxt;
    logic              latch_q;
    logic              latch_nxt;
    logic              sense_q;
    logic              sense_nxt;
    logic              run;
    logic              tick_q;

    assign flush  = RESET | tap_reset;
    assign run    = ~CASS_MOTOR & latch_q;
    assign tick_q = tick_en & run;

    tap_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (CLK28),
        .rst     (flush),
        .wr      (tap_wr),
        .wr_data (tap_data),
        .rd      (fifo_pop),
        .rd_data (fifo_dat),
        .full    (tap_full),
        .empty   (fifo_empty)
    );

    // Parser / pulse FSM: next state, FIFO pops, pulse length, counter and tape level.
    // 'pend' marks that fifo_dat holds the byte popped in the previous cycle.
    always_comb begin
        state_nxt = state;
        pend_nxt  = 1'b0;
        hdr_nxt   = hdr_cnt;
        ver_nxt   = ver_q;
        plen_nxt  = plen;
        cnt_nxt   = cnt;
        read_nxt  = read_q;
        fifo_pop  = 1'b0;
        start     = 1'b0;
        p_new     = '0;
        p_eff     = '0;
        p_half    = '0;

        case (state)
            ST_HEADER: begin
                // Header parsing runs regardless of motor/play.
                if (pend && (hdr_cnt == VER_SEEN)) begin
                    ver_nxt = clamp_version(fifo_dat);
                end
                if (hdr_cnt != HDR_END) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        pend_nxt = 1'b1;
                        hdr_nxt  = hdr_cnt + HDR_ONE;
                    end
                end else if (!pend) begin
                    state_nxt = ST_FETCH;
                end
            end

            ST_FETCH, ST_EXT0, ST_EXT1, ST_EXT2: begin
                if (!run) begin
                    // Tape stopped: keep any already-popped byte for later.
                    pend_nxt = pend;
                end else if (pend) begin
                    case (state)
                        ST_FETCH: begin
                            if (fifo_dat != 8'd0) begin
                                start = 1'b1;
                                p_new = PLEN_W'(fifo_dat) << SCALE_SHIFT;
                            end else if (ver_q == 2'd0) begin
                                start = 1'b1;
                                p_new = ZERO_LEN;
                            end else begin
                                state_nxt = ST_EXT0;
                                plen_nxt  = '0;
                            end
                        end
                        ST_EXT0: begin
                            plen_nxt[7:0] = fifo_dat;
                            state_nxt     = ST_EXT1;
                        end
                        ST_EXT1: begin
                            plen_nxt[15:8] = fifo_dat;
                            state_nxt      = ST_EXT2;
                        end
                        default: begin
                            start = 1'b1;
                            p_new = {fifo_dat, plen[15:0]};
                        end
                    endcase
                end else if (fifo_empty) begin
                    if (tap_eof) begin
                        state_nxt = ST_DONE;
                        read_nxt  = 1'b1;
                    end
                end else begin
                    fifo_pop = 1'b1;
                    pend_nxt = 1'b1;
                end
            end

            ST_RUN_A: begin
                if (tick_q) begin
                    if (cnt == ONE) begin
                        if (ver_q == 2'd2) begin
                            state_nxt = ST_FETCH;
                        end else begin
                            state_nxt = ST_RUN_B;
                            cnt_nxt   = plen - (plen >> 1);
                            read_nxt  = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
            end

            ST_RUN_B: begin
                if (tick_q) begin
                    if (cnt == ONE) begin
                        state_nxt = ST_FETCH;
                    end else begin
                        cnt_nxt = cnt - ONE;
                    end
                end
            end

            ST_DONE: begin
                read_nxt = 1'b1;
            end

            default: begin
                state_nxt = ST_HEADER;
            end
        endcase

        // New pulse: a zero length plays as one tick; full-wave pulses with a
        // zero-length low half go straight to the high half.
        if (start) begin
            p_eff    = (p_new == '0) ? ONE : p_new;
            p_half   = p_eff >> 1;
            plen_nxt = p_eff;
            if (ver_q == 2'd2) begin
                state_nxt = ST_RUN_A;
                cnt_nxt   = p_eff;
                read_nxt  = ~read_q;
            end else if (p_half == '0) begin
                state_nxt = ST_RUN_B;
                cnt_nxt   = p_eff - p_half;
                read_nxt  = 1'b1;
            end else begin
                state_nxt = ST_RUN_A;
                cnt_nxt   = p_half;
                read_nxt  = 1'b0;
            end
        end
    end

    // Play latch toggles on each play pulse, except in DONE where play clears it;
    // the sense line is the registered, inverted view of latch-and-not-done.
    always_comb begin
        latch_nxt = latch_q;
        if (play) begin
            latch_nxt = (state == ST_DONE) ? 1'b0 : ~latch_q;
        end
        sense_nxt = ~(latch_q && (state != ST_DONE));
    end

    // State and datapath registers; RESET and tap_reset both restore idle values.
    always_ff @(posedge CLK28) begin
        if (flush) begin
            state   <= ST_HEADER;
            pend    <= 1'b0;
            hdr_cnt <= '0;
            ver_q   <= 2'd0;
            plen    <= '0;
            cnt     <= '0;
            read_q  <= 1'b1;
            latch_q <= 1'b0;
            sense_q <= 1'b1;
        end else begin
            state   <= state_nxt;
            pend    <= pend_nxt;
            hdr_cnt <= hdr_nxt;
            ver_q   <= ver_nxt;
            plen    <= plen_nxt;
            cnt     <= cnt_nxt;
            read_q  <= read_nxt;
            latch_q <= latch_nxt;
            sense_q <= sense_nxt;
        end
    end

    assign CASS_READ  = read_q;
    assign CASS_SENSE = sense_q;
    assign version    = ver_q;
    assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_c16_tap_player.sv
// Directed bench for c16_tap_player: header parsing, pulse timing, gating, underrun, flush.
// Latency: ticks are spaced 4 cycles apart so inter-pulse refetch never swallows a tick.
// Backpressure: exercises tap_full and dropped writes.
module tb_c16_tap_player;

    logic       CLK28 = 1'b0;
    logic       RESET;
    logic       tick_en;
    logic       tap_reset;
    logic       tap_wr;
    logic [7:0] tap_data;
    logic       tap_eof;
    logic       tap_full;
    logic       play;
    logic       CASS_MOTOR;
    logic       CASS_READ;
    logic       CASS_SENSE;
    logic [1:0] version;
    logic       done;

    int checks = 0;
    int errors = 0;

    always #5 CLK28 = ~CLK28;

    c16_tap_player #(.FIFO_DEPTH(16)) dut (
        .CLK28      (CLK28),
        .RESET      (RESET),
        .tick_en    (tick_en),
        .tap_reset  (tap_reset),
        .tap_wr     (tap_wr),
        .tap_data   (tap_data),
        .tap_eof    (tap_eof),
        .tap_full   (tap_full),
        .play       (play),
        .CASS_MOTOR (CASS_MOTOR),
        .CASS_READ  (CASS_READ),
        .CASS_SENSE (CASS_SENSE),
        .version    (version),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK28);
    endtask

    task automatic do_reset();
        @(negedge CLK28);
        RESET = 1'b1;
        cyc(2);
        RESET = 1'b0;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        @(negedge CLK28);
        tap_wr   = 1'b1;
        tap_data = b;
        @(negedge CLK28);
        tap_wr   = 1'b0;
    endtask

    task automatic wr_header(input logic [7:0] v);
        for (int i = 0; i < 20; i++) begin
            wr_byte((i == 12) ? v : 8'(160 + i));
        end
    endtask

    task automatic pulse_play();
        @(negedge CLK28);
        play = 1'b1;
        @(negedge CLK28);
        play = 1'b0;
    endtask

    task automatic tick_once();
        @(negedge CLK28);
        tick_en = 1'b1;
        @(negedge CLK28);
        tick_en = 1'b0;
        cyc(2);
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    // Ticks until CASS_READ leaves lvl or done rises; returns limit on timeout.
    task automatic measure(input logic lvl, input int limit, output int n);
        bit stop;
        stop = 1'b0;
        n = 0;
        while (!stop && n < limit) begin
            tick_once();
            n++;
            if (CASS_READ !== lvl || done === 1'b1) stop = 1'b1;
        end
    endtask

    initial begin
        int n;
        int bad;
        RESET = 1'b0; tick_en = 1'b0; tap_reset = 1'b0; tap_wr = 1'b0;
        tap_data = 8'h00; tap_eof = 1'b0; play = 1'b0; CASS_MOTOR = 1'b0;

        // Reset values
        do_reset();
        chk("rst_full", 32'(tap_full), 0);
        chk("rst_read", 32'(CASS_READ), 1);
        chk("rst_sense", 32'(CASS_SENSE), 1);
        chk("rst_version", 32'(version), 0);
        chk("rst_done", 32'(done), 0);

        // Version 1, byte 0x30 -> P=384, 192 low / 192 high
        wr_header(8'd1);
        wr_byte(8'h30);
        tap_eof = 1'b1;
        cyc(4);
        chk("v1_version", 32'(version), 1);
        chk("v1_read_before_play", 32'(CASS_READ), 1);
        pulse_play();
        cyc(3);
        chk("v1_sense_low", 32'(CASS_SENSE), 0);
        chk("v1_read_low", 32'(CASS_READ), 0);
        measure(1'b0, 400, n);
        chk("v1_low_ticks", n, 192);
        measure(1'b1, 400, n);
        chk("v1_high_ticks", n, 192);
        cyc(2);
        chk("v1_done", 32'(done), 1);
        chk("v1_done_read", 32'(CASS_READ), 1);
        chk("v1_done_sense", 32'(CASS_SENSE), 1);

        // Version 1 extended length 00 10 27 00 -> P=10000
        tap_eof = 1'b0;
        do_reset();
        wr_header(8'd1);
        wr_byte(8'h00); wr_byte(8'h10); wr_byte(8'h27); wr_byte(8'h00);
        tap_eof = 1'b1;
        pulse_play();
        cyc(12);
        chk("ext_read_low", 32'(CASS_READ), 0);
        measure(1'b0, 6000, n);
        chk("ext_low_ticks", n, 5000);
        measure(1'b1, 6000, n);
        chk("ext_high_ticks", n, 5000);
        cyc(2);
        chk("ext_done", 32'(done), 1);

        // Version 2 half-wave 0x02 0x03 -> 16 then 24 ticks
        tap_eof = 1'b0;
        do_reset();
        wr_header(8'd2);
        wr_byte(8'h02); wr_byte(8'h03);
        tap_eof = 1'b1;
        chk("v2_version", 32'(version), 2);
        pulse_play();
        cyc(6);
        chk("v2_first_toggle", 32'(CASS_READ), 0);
        measure(1'b0, 100, n);
        chk("v2_hold16", n, 16);
        chk("v2_second_toggle", 32'(CASS_READ), 1);
        measure(1'b1, 100, n);
        chk("v2_hold24", n, 24);
        cyc(2);
        chk("v2_done", 32'(done), 1);

        // Motor gating mid RUN_A
        tap_eof = 1'b0;
        do_reset();
        wr_header(8'd1);
        wr_byte(8'h30);
        tap_eof = 1'b1;
        pulse_play();
        cyc(6);
        chk("gate_read_low", 32'(CASS_READ), 0);
        tick_n(50);
        CASS_MOTOR = 1'b1;
        tick_n(1000);
        chk("gate_read_frozen", 32'(CASS_READ), 0);
        CASS_MOTOR = 1'b0;
        measure(1'b0, 400, n);
        chk("gate_remaining_low", n, 142);

        // Underrun, resume and FIFO full
        tap_eof = 1'b0;
        do_reset();
        wr_header(8'd0);
        wr_byte(8'h10);
        pulse_play();
        cyc(6);
        chk("ur_read_low", 32'(CASS_READ), 0);
        measure(1'b0, 100, n);
        chk("ur_low_ticks", n, 64);
        tick_n(64);
        tick_n(50);
        chk("ur_hold_read", 32'(CASS_READ), 1);
        chk("ur_not_done", 32'(done), 0);
        wr_byte(8'h10);
        cyc(6);
        chk("ur_resume_low", 32'(CASS_READ), 0);
        measure(1'b0, 100, n);
        chk("ur_resume_low_ticks", n, 64);
        CASS_MOTOR = 1'b1;
        for (int i = 0; i < 15; i++) wr_byte(8'h01);
        chk("fill15_not_full", 32'(tap_full), 0);
        wr_byte(8'h01);
        chk("fill16_full", 32'(tap_full), 1);
        wr_byte(8'h05);
        wr_byte(8'h05);
        chk("full_stays", 32'(tap_full), 1);
        tap_eof = 1'b1;
        CASS_MOTOR = 1'b0;
        measure(1'b1, 100, n);
        chk("ur_resume_high_ticks", n, 64);
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            measure(1'b0, 20, n);
            if (n != 4) bad++;
            measure(1'b1, 20, n);
            if (n != 4) bad++;
        end
        chk("drain16_pulses", bad, 0);
        cyc(2);
        chk("drain_done", 32'(done), 1);

        // tap_reset while stalled in EXT1, then a fresh header with byte12=3
        tap_eof = 1'b0;
        do_reset();
        wr_header(8'd1);
        wr_byte(8'h00); wr_byte(8'h10);
        pulse_play();
        cyc(10);
        chk("pre_flush_sense", 32'(CASS_SENSE), 0);
        @(negedge CLK28);
        tap_reset = 1'b1;
        @(negedge CLK28);
        tap_reset = 1'b0;
        chk("flush_full", 32'(tap_full), 0);
        chk("flush_read", 32'(CASS_READ), 1);
        chk("flush_sense", 32'(CASS_SENSE), 1);
        chk("flush_version", 32'(version), 0);
        chk("flush_done", 32'(done), 0);
        wr_header(8'd3);
        wr_byte(8'h02);
        tap_eof = 1'b1;
        cyc(2);
        chk("v3_as_v2", 32'(version), 2);
        pulse_play();
        cyc(6);
        chk("post_flush_toggle", 32'(CASS_READ), 0);
        measure(1'b0, 100, n);
        chk("post_flush_hold16", n, 16);
        cyc(2);
        chk("post_flush_done", 32'(done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
